// File: rtl/layered_color_mapper.sv
// layered_color_mapper
// Resolves per-layer sprite hit flags to a colour from a writable palette,
// draws the gradient background where no layer hits, and runs the
// frame-synchronous end-of-game sequence: fade to a win/lose target colour,
// then a periodic black flash on the lost screen.
// Two-stage pipeline: stage 1 resolves the scene colour, stage 2 applies
// game state, fade level and flash.
// Optional feature macro: LAYERED_COLOR_MAPPER_FADE_EN
//   defined   : per-frame blend from scene to target over 2^FADE_LOG2 frames
//   undefined : no blend multipliers; the target colour applies immediately
//               on entry to WON/LOST
module layered_color_mapper #(
    parameter int NUM_LAYERS   = 4,
    parameter int FADE_LOG2    = 4,
    parameter int FLASH_FRAMES = 8,
    localparam int IDX_W       = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  frame_start,
    input  logic [NUM_LAYERS-1:0] layer_hit,
    input  logic [9:0]            DrawX,
    input  logic [9:0]            DrawY,
    input  logic                  end_game_won,
    input  logic                  end_game_lost,
    input  logic                  pal_we,
    input  logic [IDX_W-1:0]      pal_idx,
    input  logic [23:0]           pal_data,
    output logic [7:0]            VGA_R,
    output logic [7:0]            VGA_G,
    output logic [7:0]            VGA_B,
    output logic [1:0]            game_state,
    output logic                  fade_done
);

    localparam int LVL_W = FADE_LOG2 + 1;
    localparam int CNT_W = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
    localparam logic [LVL_W-1:0] M_LVL = LVL_W'(2 ** FADE_LOG2);

`ifdef LAYERED_COLOR_MAPPER_FADE_EN
    // Fade starts from the untouched scene and walks toward the target.
    localparam logic [LVL_W-1:0] LVL_ON_ENTRY = '0;
`else
    // No blend hardware: jump straight to the fully faded level.
    localparam logic [LVL_W-1:0] LVL_ON_ENTRY = M_LVL;
`endif

    typedef enum logic [1:0] {
        ST_PLAY = 2'b00,
        ST_WON  = 2'b01,
        ST_LOST = 2'b10
    } state_t;

    genvar gi;

    // ------------------------------------------------------------------
    // Palette: one 24-bit register per layer, each with its own reset colour
    // ------------------------------------------------------------------
    logic [NUM_LAYERS*24-1:0] w_pal_flat;

    for (gi = 0; gi < NUM_LAYERS; gi++) begin : g_pal
        localparam logic [23:0] RST_VAL = (gi == 0) ? 24'hFF0000 :
                                          (gi == 1) ? 24'hFFFFFF :
                                          (gi == 2) ? 24'h00FF00 :
                                                      24'hFFFF00;
        logic [23:0] r_entry;

        // Entry update on a write strobe addressed to this layer
        always_ff @(posedge Clk) begin
            if (Reset) begin
                r_entry <= RST_VAL;
            end else if (pal_we && (int'(pal_idx) == gi)) begin
                r_entry <= pal_data;
            end
        end

        assign w_pal_flat[gi*24 +: 24] = r_entry;
    end

    // ------------------------------------------------------------------
    // Stage 1: priority resolve (lowest set bit wins) or gradient background
    // ------------------------------------------------------------------
    logic [7:0]  w_bg_b;
    logic [23:0] w_scene;
    logic [23:0] r_s1_rgb;
    logic [6:0]  r_s1_x7;

    assign w_bg_b = 8'h7F - {1'b0, DrawX[9:3]};

    // Walk from the lowest-priority layer up so the lowest index overrides
    always_comb begin
        w_scene = {8'h3F, 8'h00, w_bg_b};
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (layer_hit[i]) begin
                w_scene = w_pal_flat[i*24 +: 24];
            end
        end
    end

    // Stage-1 pipeline registers: scene colour and the column bits the
    // won-screen gradient needs one stage later
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_s1_rgb <= '0;
            r_s1_x7  <= '0;
        end else begin
            r_s1_rgb <= w_scene;
            r_s1_x7  <= DrawX[9:3];
        end
    end

    // ------------------------------------------------------------------
    // Game state machine: only moves on frame_start, WON beats LOST
    // ------------------------------------------------------------------
    state_t r_state;
    state_t w_state_next;
    logic   w_enter_end;

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= ST_PLAY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: end-game requests are looked at only on a frame boundary
    always_comb begin
        w_state_next = r_state;
        if ((r_state == ST_PLAY) && frame_start) begin
            if (end_game_won) begin
                w_state_next = ST_WON;
            end else if (end_game_lost) begin
                w_state_next = ST_LOST;
            end
        end
    end

    assign w_enter_end = (r_state == ST_PLAY) && (w_state_next != ST_PLAY);

    // ------------------------------------------------------------------
    // Fade level: cleared (or preset) on entry, +1 per later frame, saturating
    // ------------------------------------------------------------------
    logic [LVL_W-1:0] r_lvl;
    logic             w_fade_done;

    // Fade level counter
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_lvl <= '0;
        end else if (w_enter_end) begin
            r_lvl <= LVL_ON_ENTRY;
        end else if ((r_state != ST_PLAY) && frame_start && (r_lvl != M_LVL)) begin
            r_lvl <= r_lvl + LVL_W'(1);
        end
    end

    assign w_fade_done = (r_lvl == M_LVL);

    // ------------------------------------------------------------------
    // Lost-screen flash: toggles every FLASH_FRAMES frames once faded out
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] r_flash_cnt;
    logic             r_flash_phase;

    // Flash counter and phase; held at zero until the lost fade completes
    always_ff @(posedge Clk) begin
        if (Reset || !((r_state == ST_LOST) && w_fade_done)) begin
            r_flash_cnt   <= '0;
            r_flash_phase <= 1'b0;
        end else if (frame_start) begin
            if (int'(r_flash_cnt) == FLASH_FRAMES - 1) begin
                r_flash_cnt   <= '0;
                r_flash_phase <= ~r_flash_phase;
            end else begin
                r_flash_cnt <= r_flash_cnt + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: target colour, blend, flash blanking
    // ------------------------------------------------------------------
    logic [7:0]  w_won_r;
    logic [23:0] w_target;
    logic [23:0] w_blend;
    logic [23:0] w_final;
    logic [23:0] r_vga_rgb;

    assign w_won_r = 8'h7F - {1'b0, r_s1_x7};

    // End-screen target colour for the current end state
    always_comb begin
        w_target = 24'hFF0000;
        if (r_state == ST_WON) begin
            w_target = {w_won_r, 8'hB0, 8'h8A};
        end
    end

`ifdef LAYERED_COLOR_MAPPER_FADE_EN
    localparam int MIX_W = 9 + FADE_LOG2;
    logic [LVL_W-1:0] w_lvl_inv;

    assign w_lvl_inv = M_LVL - r_lvl;

    // Per-channel linear blend; the weights sum to M so the shift normalises
    for (gi = 0; gi < 3; gi++) begin : g_blend
        logic [MIX_W-1:0] w_mix;
        assign w_mix = MIX_W'(r_s1_rgb[gi*8 +: 8]) * MIX_W'(w_lvl_inv)
                     + MIX_W'(w_target[gi*8 +: 8]) * MIX_W'(r_lvl);
        assign w_blend[gi*8 +: 8] = 8'(w_mix >> FADE_LOG2);
    end
`else
    assign w_blend = w_target;
`endif

    // Final colour select: scene in play, blended colour at game end,
    // black during the dark half of the lost flash
    always_comb begin
        w_final = (r_state == ST_PLAY) ? r_s1_rgb : w_blend;
        if (r_flash_phase) begin
            w_final = '0;
        end
    end

    // Stage-2 output register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_vga_rgb <= '0;
        end else begin
            r_vga_rgb <= w_final;
        end
    end

    assign VGA_R      = r_vga_rgb[23:16];
    assign VGA_G      = r_vga_rgb[15:8];
    assign VGA_B      = r_vga_rgb[7:0];
    assign game_state = r_state;
    assign fade_done  = w_fade_done;

    // Row coordinate and sub-8-pixel column bits do not affect the colour
    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, DrawY, DrawX[2:0]};

endmodule

// File: tb/tb_layered_color_mapper.sv
// Testbench for layered_color_mapper: directed checks with hand-computed
// values plus randomized stimulus compared every cycle against a
// frame-count based behavioural model.
`timescale 1ns/1ps
module tb_layered_color_mapper;

    localparam int NL = 4;
    localparam int FL = 4;
    localparam int FF = 8;
    localparam int M  = 16;
`ifdef LAYERED_COLOR_MAPPER_FADE_EN
    localparam bit FADE = 1'b1;
`else
    localparam bit FADE = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        frame_start = 1'b0;
    logic [3:0]  layer_hit = '0;
    logic [9:0]  DrawX = '0;
    logic [9:0]  DrawY = '0;
    logic        end_game_won = 1'b0;
    logic        end_game_lost = 1'b0;
    logic        pal_we = 1'b0;
    logic [1:0]  pal_idx = '0;
    logic [23:0] pal_data = '0;
    logic [7:0]  VGA_R, VGA_G, VGA_B;
    logic [1:0]  game_state;
    logic        fade_done;

    int n_vec = 0;
    int n_mis = 0;
    bit chk_en = 1'b0;

    always #5 Clk = ~Clk;

    layered_color_mapper #(
        .NUM_LAYERS   (NL),
        .FADE_LOG2    (FL),
        .FLASH_FRAMES (FF)
    ) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .frame_start   (frame_start),
        .layer_hit     (layer_hit),
        .DrawX         (DrawX),
        .DrawY         (DrawY),
        .end_game_won  (end_game_won),
        .end_game_lost (end_game_lost),
        .pal_we        (pal_we),
        .pal_idx       (pal_idx),
        .pal_data      (pal_data),
        .VGA_R         (VGA_R),
        .VGA_G         (VGA_G),
        .VGA_B         (VGA_B),
        .game_state    (game_state),
        .fade_done     (fade_done)
    );

    // ---------------- behavioural model ----------------
    // State is tracked as "which end state" plus "frames seen since entry";
    // fade level and flash phase are derived from that count arithmetically.
    logic [23:0] m_pal [NL];
    logic [23:0] m_s1;
    logic [6:0]  m_x7;
    logic [23:0] m_vga;
    int          m_state;
    int          m_frames;

    function automatic int lvl_of(input int st, input int fr);
        if (st == 0) return 0;
        if (FADE) return (fr < M) ? fr : M;
        return M;
    endfunction

    function automatic bit phase_of(input int st, input int fr);
        int cnt;
        if (st != 2 || lvl_of(st, fr) != M) return 1'b0;
        cnt = fr - (FADE ? M : 0);
        return ((cnt / FF) % 2) == 1;
    endfunction

    function automatic logic [23:0] scene_of(input logic [3:0] h, input logic [9:0] x);
        for (int i = 0; i < NL; i++) begin
            if (h[i]) return m_pal[i];
        end
        return {8'h3F, 8'h00, 8'h7F - {1'b0, x[9:3]}};
    endfunction

    function automatic logic [23:0] exp_out(input logic [23:0] s1, input logic [6:0] x7,
                                            input int st, input int fr);
        int l;
        logic [23:0] t;
        logic [23:0] o;
        if (st == 0) return s1;
        if (phase_of(st, fr)) return 24'h000000;
        l = lvl_of(st, fr);
        t = (st == 1) ? {8'h7F - {1'b0, x7}, 8'hB0, 8'h8A} : 24'hFF0000;
        for (int ch = 0; ch < 3; ch++) begin
            o[ch*8 +: 8] = 8'((int'(s1[ch*8 +: 8]) * (M - l) + int'(t[ch*8 +: 8]) * l) >> FL);
        end
        return o;
    endfunction

    always @(posedge Clk) begin
        if (Reset) begin
            m_vga    <= '0;
            m_s1     <= '0;
            m_x7     <= '0;
            m_state  <= 0;
            m_frames <= 0;
            m_pal[0] <= 24'hFF0000;
            m_pal[1] <= 24'hFFFFFF;
            m_pal[2] <= 24'h00FF00;
            m_pal[3] <= 24'hFFFF00;
        end else begin
            m_vga <= exp_out(m_s1, m_x7, m_state, m_frames);
            m_s1  <= scene_of(layer_hit, DrawX);
            m_x7  <= DrawX[9:3];
            if (pal_we && int'(pal_idx) < NL) m_pal[pal_idx] <= pal_data;
            if (m_state == 0) begin
                if (frame_start && end_game_won) m_state <= 1;
                else if (frame_start && end_game_lost) m_state <= 2;
                m_frames <= 0;
            end else if (frame_start) begin
                m_frames <= m_frames + 1;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] rgb();
        return {VGA_R, VGA_G, VGA_B};
    endfunction

    always @(negedge Clk) begin
        if (chk_en) begin
            chk("model_vga", {8'h0, rgb()}, {8'h0, m_vga});
            chk("model_game_state", {30'h0, game_state}, {30'h0, m_state[1:0]});
            chk("model_fade_done", {31'h0, fade_done}, {31'h0, lvl_of(m_state, m_frames) == M});
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic pulse();
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        tick(3);
    endtask

    initial begin
        tick(3);
        chk_en = 1'b1;

        // Background gradient after reset
        Reset = 1'b0;
        layer_hit = 4'b0000;
        DrawX = 10'h080;
        tick(2);
        chk("bg_color", {8'h0, rgb()}, 32'h003F006F);
        chk("reset_game_state", {30'h0, game_state}, 32'h0);
        chk("reset_fade_done", {31'h0, fade_done}, 32'h0);

        // Palette priority and write timing
        layer_hit = 4'b0110;
        tick(2);
        chk("pal1_default", {8'h0, rgb()}, 32'h00FFFFFF);
        pal_we = 1'b1; pal_idx = 2'd1; pal_data = 24'h123456;
        tick(1);
        pal_we = 1'b0;
        tick(1);
        chk("pal_same_cycle_old", {8'h0, rgb()}, 32'h00FFFFFF);
        tick(1);
        chk("pal_new_value", {8'h0, rgb()}, 32'h00123456);

        // Won (both requests) with scene FFFFFF at DrawX = 0
        pal_we = 1'b1; pal_idx = 2'd1; pal_data = 24'hFFFFFF;
        tick(1);
        pal_we = 1'b0; layer_hit = 4'b0010; DrawX = 10'd0;
        tick(2);
        frame_start = 1'b1; end_game_won = 1'b1; end_game_lost = 1'b1;
        tick(1);
        frame_start = 1'b0; end_game_won = 1'b0; end_game_lost = 1'b0;
        chk("won_state", {30'h0, game_state}, 32'h1);
`ifdef LAYERED_COLOR_MAPPER_FADE_EN
        chk("won_fade_not_done", {31'h0, fade_done}, 32'h0);
        tick(1);
        chk("won_lvl0_scene", {8'h0, rgb()}, 32'h00FFFFFF);
        repeat (8) pulse();
        chk("won_half_fade_r", {24'h0, VGA_R}, 32'hBF);
        repeat (8) pulse();
        chk("won_fade_done", {31'h0, fade_done}, 32'h1);
        chk("won_target", {8'h0, rgb()}, 32'h007FB08A);
`else
        chk("won_fade_done_now", {31'h0, fade_done}, 32'h1);
        tick(1);
        chk("won_target_now", {8'h0, rgb()}, 32'h007FB08A);
        repeat (3) pulse();
        chk("won_no_flash", {8'h0, rgb()}, 32'h007FB08A);
`endif

        // Lost: ignored without frame_start, then fade and flash
        Reset = 1'b1;
        tick(1);
        Reset = 1'b0;
        end_game_lost = 1'b1;
        tick(2);
        chk("lost_needs_frame", {30'h0, game_state}, 32'h0);
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0; end_game_lost = 1'b0;
        chk("lost_state", {30'h0, game_state}, 32'h2);
        repeat (FADE ? M : 0) pulse();
        tick(2);
        chk("lost_fade_done", {31'h0, fade_done}, 32'h1);
        chk("lost_target", {8'h0, rgb()}, 32'h00FF0000);
        repeat (7) pulse();
        chk("flash_before_toggle", {8'h0, rgb()}, 32'h00FF0000);
        pulse();
        chk("flash_dark", {8'h0, rgb()}, 32'h00000000);
        repeat (8) pulse();
        chk("flash_light", {8'h0, rgb()}, 32'h00FF0000);

        // Randomized traffic with occasional resets
        for (int c = 0; c < 4000; c++) begin
            layer_hit     = 4'($urandom);
            DrawX         = 10'($urandom);
            DrawY         = 10'($urandom);
            pal_we        = ($urandom_range(7, 0) == 0);
            pal_idx       = 2'($urandom);
            pal_data      = 24'($urandom);
            frame_start   = ($urandom_range(3, 0) == 0);
            end_game_won  = ($urandom_range(31, 0) == 0);
            end_game_lost = ($urandom_range(15, 0) == 0);
            Reset         = ($urandom_range(599, 0) == 0);
            tick(1);
        end

        // Reset in the middle of a lost fade / flash
        pal_we = 1'b0; frame_start = 1'b0; end_game_won = 1'b0; end_game_lost = 1'b0;
        Reset = 1'b1;
        tick(1);
        Reset = 1'b0; layer_hit = 4'b0010;
        tick(2);
        frame_start = 1'b1; end_game_lost = 1'b1;
        tick(1);
        frame_start = 1'b0; end_game_lost = 1'b0;
        repeat (12) pulse();
        Reset = 1'b1;
        tick(1);
        chk("midrst_game_state", {30'h0, game_state}, 32'h0);
        chk("midrst_fade_done", {31'h0, fade_done}, 32'h0);
        chk("midrst_vga", {8'h0, rgb()}, 32'h0);
        Reset = 1'b0; layer_hit = 4'b0001;
        tick(1);
        layer_hit = 4'b0010;
        tick(1);
        chk("rst_pal0", {8'h0, rgb()}, 32'h00FF0000);
        layer_hit = 4'b0100;
        tick(1);
        chk("rst_pal1", {8'h0, rgb()}, 32'h00FFFFFF);
        layer_hit = 4'b1000;
        tick(1);
        chk("rst_pal2", {8'h0, rgb()}, 32'h0000FF00);
        tick(1);
        chk("rst_pal3", {8'h0, rgb()}, 32'h00FFFF00);

        tick(2);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
